// File: rtl/vga_frame_sched_pkg.sv
// Shared types and constants for the VGA frame update scheduler.
package vga_sched_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [1:0] PH_PADDLE  = 2'd0;
  localparam logic [1:0] PH_BALL    = 2'd1;
  localparam logic [1:0] PH_COLLIDE = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PADDLE  = 3'd1,
    BALL    = 3'd2,
    COLLIDE = 3'd3,
    DONE    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/vga_frame_sched_if.sv
// Update handshake between the frame scheduler (master) and game logic (slave).
interface vga_frame_sched_if;
  logic       upd_req;
  logic [1:0] upd_phase;
  logic       upd_ack;

  modport master (output upd_req, output upd_phase, input upd_ack);
  modport slave  (input upd_req, input upd_phase, output upd_ack);
endinterface

// File: rtl/vga_frame_sched_watchdog.sv
// Per-phase watchdog: counts cycles while start (the phase request) is high
// and flags expiry on the TIMEOUT-th unacknowledged cycle.
module vga_phase_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // The request drops for a cycle between phases, which clears the count on entry.
  always_ff @(posedge clk) begin
    if (!reset || !start || ack) count <= '0;
    else                         count <= count + CW'(1);
  end

  assign expired = start && !ack && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/vga_frame_sched.sv
// Frame update scheduler: at the first blanking line it walks game logic through
// PADDLE/BALL/COLLIDE update phases. Define WATCHDOG_EN for a per-phase timeout.
//   state   | meaning
//   IDLE    | waiting for a refresh point
//   PADDLE  | paddle update requested (req low for one cycle on entry gaps)
//   BALL    | ball update requested
//   COLLIDE | collision update requested
//   DONE    | sequence complete, one cycle before IDLE
module vga_frame_sched #(
  parameter int V_ACTIVE = vga_sched_pkg::V_ACTIVE,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              pause,
  input  logic              err_clr,
  vga_frame_sched_if.master upd,
  output logic              frame_tick,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              overrun,
  output logic              timeout_err
);
  import vga_sched_pkg::*;

  sched_state_t state;
  logic refr, top_tick, expired, advance, ovr_set;
  logic unused_video_on;

  assign unused_video_on = video_on;
  assign refr     = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'(V_ACTIVE));
  assign top_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign advance  = upd.upd_req && (upd.upd_ack || expired);
  assign ovr_set  = (refr && state != IDLE) || (top_tick && busy);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      upd.upd_req   <= 1'b0;
      upd.upd_phase <= PH_PADDLE;
      busy          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (refr && !pause) begin
            state         <= PADDLE;
            upd.upd_req   <= 1'b1;
            upd.upd_phase <= PH_PADDLE;
            busy          <= 1'b1;
          end
        end
        // On advance the request drops for one cycle, then the next phase re-raises it.
        PADDLE: begin
          if (advance) begin
            state         <= BALL;
            upd.upd_req   <= 1'b0;
            upd.upd_phase <= PH_BALL;
          end else begin
            upd.upd_req   <= 1'b1;
          end
        end
        BALL: begin
          if (advance) begin
            state         <= COLLIDE;
            upd.upd_req   <= 1'b0;
            upd.upd_phase <= PH_COLLIDE;
          end else begin
            upd.upd_req   <= 1'b1;
          end
        end
        COLLIDE: begin
          if (advance) begin
            state       <= DONE;
            upd.upd_req <= 1'b0;
          end else begin
            upd.upd_req <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          upd.upd_phase <= PH_PADDLE;
          busy          <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          upd.upd_req   <= 1'b0;
          upd.upd_phase <= PH_PADDLE;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  // A set event in the same cycle as err_clr keeps the flag high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      overrun    <= 1'b0;
    end else begin
      frame_tick <= refr;
      if (refr) frame_cnt <= frame_cnt + 16'd1;
      overrun    <= ovr_set | (overrun & ~err_clr);
    end
  end

`ifdef WATCHDOG_EN
  vga_phase_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (upd.upd_req),
    .ack     (upd.upd_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) timeout_err <= 1'b0;
    else        timeout_err <= expired | (timeout_err & ~err_clr);
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_sched.sv
// Scoreboard bench for vga_frame_sched: stimulus pushes expected frame counts and
// phase codes, a monitor pops and compares when the DUT presents them.
module tb_vga_frame_sched;
  localparam int VA  = 480;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic        pause = 1'b0;
  logic        err_clr = 1'b0;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic        frame_tick, busy, overrun, timeout_err;
  logic [15:0] frame_cnt;

  vga_frame_sched_if upd_bus();

  vga_frame_sched #(.V_ACTIVE(VA), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .p_tick      (p_tick),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pause       (pause),
    .err_clr     (err_clr),
    .upd         (upd_bus),
    .frame_tick  (frame_tick),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [1:0]  exp_phase[$];
  logic [15:0] exp_frame[$];
  logic [15:0] model_cnt = 16'd0;
  bit          bulk = 1'b0;
  bit          auto_ack = 1'b0;
  int          ack_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // One refresh point; the model counts frames and, if a sequence should start, queues its phases.
  task automatic refr(input logic pz, input bit expect_seq);
    pause   = pz;
    p_tick  = 1'b1;
    pixel_x = 10'd0;
    pixel_y = 10'(VA);
    model_cnt = model_cnt + 16'd1;
    exp_frame.push_back(model_cnt);
    if (expect_seq) begin
      exp_phase.push_back(2'd0);
      exp_phase.push_back(2'd1);
      exp_phase.push_back(2'd2);
    end
    @(negedge clk);
    p_tick  = 1'b0;
    pixel_x = 10'd17;
    pixel_y = 10'd100;
  endtask

  task automatic top_tick();
    p_tick  = 1'b1;
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    @(negedge clk);
    p_tick  = 1'b0;
    pixel_x = 10'd17;
    pixel_y = 10'd100;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout_fail("wait_idle");
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!upd_bus.upd_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!upd_bus.upd_req) timeout_fail("wait_req");
  endtask

  task automatic manual_ack(input int budget);
    wait_req(budget);
    upd_bus.upd_ack = 1'b1;
    @(negedge clk);
    upd_bus.upd_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin : monitor
    logic        prev_req;
    int          low_run;
    logic [1:0]  ep;
    logic [15:0] ef;
    prev_req = 1'b0;
    low_run  = 100;
    forever begin
      @(negedge clk);
      if (frame_tick === 1'b1 && !bulk) begin
        if (exp_frame.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_tick: frame_cnt=%0h with no frame expected", frame_cnt);
        end else begin
          ef = exp_frame.pop_front();
          check("frame_cnt_on_tick", frame_cnt, ef);
        end
      end
      if (upd_bus.upd_req === 1'b1 && !prev_req) begin
        if (exp_phase.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: phase=%0d with no phase expected", upd_bus.upd_phase);
        end else begin
          ep = exp_phase.pop_front();
          check("phase_seq", upd_bus.upd_phase, ep);
          check("busy_with_req", busy, 1'b1);
          if (ep != 2'd0) check("gap_cycles", low_run, 1);
        end
        low_run = 0;
      end
      if (upd_bus.upd_req !== 1'b1) low_run++;
      prev_req = (upd_bus.upd_req === 1'b1);
    end
  end

  initial begin : responder
    int d;
    upd_bus.upd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && upd_bus.upd_req) begin
        d = (ack_delay > 0) ? ack_delay : int'($urandom_range(1, 6));
        repeat (d - 1) @(negedge clk);
        upd_bus.upd_ack = 1'b1;
        @(negedge clk);
        upd_bus.upd_ack = 1'b0;
      end
    end
  end

  initial begin : main
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_upd_req", upd_bus.upd_req, 1'b0);
    check("rst_upd_phase", upd_bus.upd_phase, 2'd0);
    check("rst_frame_tick", frame_tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);

    // Basic sequence, ack after 5 cycles per phase.
    ack_delay = 5;
    auto_ack  = 1'b1;
    refr(1'b0, 1'b1);
    check("frame_tick_next_cycle", frame_tick, 1'b1);
    check("req_on_start", upd_bus.upd_req, 1'b1);
    @(negedge clk);
    check("frame_tick_one_cycle", frame_tick, 1'b0);
    wait_idle(200);
    check("busy_after_seq", busy, 1'b0);
    check("frame_cnt_first", frame_cnt, model_cnt);

    // Paused refresh points only count frames.
    for (int i = 0; i < 3; i++) begin
      refr(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check("busy_while_paused", busy, 1'b0);
    end
    check("frame_cnt_paused", frame_cnt, model_cnt);
    pause = 1'b0;

    // Random frames, random ack latency, pause toggled mid-sequence.
    ack_delay = 0;
    for (int i = 0; i < 25; i++) begin
      logic pz;
      pz = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      refr(pz, !pz);
      pause = 1'($urandom_range(0, 1));
      wait_idle(300);
    end
    pause = 1'b0;
    check("frame_cnt_random", frame_cnt, model_cnt);

    // Overrun handling with ack withheld in BALL.
    auto_ack = 1'b0;
    @(negedge clk);
    top_tick();
    check("no_overrun_when_idle", overrun, 1'b0);
    refr(1'b0, 1'b1);
    manual_ack(20);
    wait_req(20);
    check("in_ball", upd_bus.upd_phase, 2'd1);
    top_tick();
    check("overrun_top_tick", overrun, 1'b1);
    pulse_clr();
    check("overrun_cleared", overrun, 1'b0);
    refr(1'b0, 1'b0);
    check("overrun_refr_busy", overrun, 1'b1);
    check("no_restart_req", upd_bus.upd_req, 1'b1);
    check("no_restart_phase", upd_bus.upd_phase, 2'd1);
    err_clr = 1'b1;
    top_tick();
    err_clr = 1'b0;
    check("set_beats_clear", overrun, 1'b1);
    pulse_clr();
    check("overrun_cleared2", overrun, 1'b0);
    auto_ack = 1'b1;
    wait_idle(200);
    auto_ack = 1'b0;
    @(negedge clk);

    // Phase with no ack.
    refr(1'b0, 1'b1);
`ifdef WATCHDOG_EN
    repeat (TMO - 1) @(negedge clk);
    check("wd_before_limit_req", upd_bus.upd_req, 1'b1);
    check("wd_before_limit_err", timeout_err, 1'b0);
    @(negedge clk);
    check("wd_expired_req", upd_bus.upd_req, 1'b0);
    check("wd_expired_err", timeout_err, 1'b1);
    wait_idle(200);
    check("wd_err_sticky", timeout_err, 1'b1);
    pulse_clr();
    check("wd_err_cleared", timeout_err, 1'b0);
`else
    repeat (40) @(negedge clk);
    check("no_wd_req", upd_bus.upd_req, 1'b1);
    check("no_wd_phase", upd_bus.upd_phase, 2'd0);
    check("no_wd_busy", busy, 1'b1);
    check("no_wd_err", timeout_err, 1'b0);
    auto_ack = 1'b1;
    wait_idle(200);
    auto_ack = 1'b0;
`endif

    // Run frame_cnt up to 0xFFFF with back-to-back paused refresh points.
    @(negedge clk);
    bulk    = 1'b1;
    n       = 16'hFFFF - int'(model_cnt);
    pause   = 1'b1;
    p_tick  = 1'b1;
    pixel_x = 10'd0;
    pixel_y = 10'(VA);
    repeat (n) begin
      model_cnt = model_cnt + 16'd1;
      @(negedge clk);
    end
    p_tick  = 1'b0;
    pixel_y = 10'd100;
    pause   = 1'b0;
    @(negedge clk);
    bulk = 1'b0;
    check("frame_cnt_preload", frame_cnt, model_cnt);
    check("busy_after_bulk", busy, 1'b0);

    ack_delay = 5;
    auto_ack  = 1'b1;
    refr(1'b0, 1'b1);
    check("frame_cnt_wrap", frame_cnt, model_cnt);
    n = 0;
    while (!(upd_bus.upd_req && upd_bus.upd_phase == 2'd2) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(upd_bus.upd_req && upd_bus.upd_phase == 2'd2)) timeout_fail("wait_collide");
    reset    = 1'b0;
    auto_ack = 1'b0;
    model_cnt = 16'd0;
    @(negedge clk);
    check("reset_drops_req", upd_bus.upd_req, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_frame_cnt", frame_cnt, model_cnt);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no_resume_req", upd_bus.upd_req, 1'b0);
    check("no_resume_busy", busy, 1'b0);

    check("pending_phases", exp_phase.size(), 0);
    check("pending_frames", exp_frame.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_frame_sched.md
VGA_FRAME_SCHED -- requirements
Module: vga_frame_sched

Interface
REQ-001 SHALL have parameter V_ACTIVE, default 480: number of visible lines; the first blanking line is pixel_y == V_ACTIVE.
REQ-002 SHALL have parameter TIMEOUT, default 1023: watchdog limit per phase, in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low.
REQ-005 SHALL have ports p_tick, video_on, input, 1 bit each: pixel strobe and visible-area flag from vga_sync.
REQ-006 SHALL have ports pixel_x and pixel_y, input, 10 bits each: the vga_sync counters.
REQ-007 SHALL have port pause, input, 1 bit: level; when high, no new update sequence starts.
REQ-008 SHALL have port err_clr, input, 1 bit: pulse; clears the sticky flags.
REQ-009 SHALL have port upd_ack, input, 1 bit: game-logic completion of the current phase.
REQ-010 SHALL have port upd_req, output, 1 bit: level; a phase request.
REQ-011 SHALL have port upd_phase, output, 2 bits: 0 = PADDLE, 1 = BALL, 2 = COLLIDE.
REQ-012 SHALL have ports frame_tick and busy, output, 1 bit each.
REQ-013 SHALL have port frame_cnt, output, 16 bits.
REQ-014 SHALL have ports overrun and timeout_err, output, 1 bit each, both sticky.

Function
REQ-015 refr event SHALL be p_tick && pixel_x == 0 && pixel_y == V_ACTIVE, evaluated each clk.
REQ-016 frame_tick SHALL be a registered, one-cycle pulse asserted the cycle after refr; it fires regardless of pause or FSM state.
REQ-017 frame_cnt SHALL increment by 1 on every refr and wrap from 0xFFFF to 0x0000.
REQ-018 The FSM SHALL have states IDLE, PADDLE, BALL, COLLIDE and DONE.
REQ-019 From IDLE, the FSM SHALL go to PADDLE on refr && !pause; otherwise it stays in IDLE.
REQ-020 In PADDLE, BALL and COLLIDE, the outputs SHALL be upd_req = 1 and upd_phase = the matching code; the FSM advances PADDLE -> BALL -> COLLIDE -> DONE on the cycle upd_ack is sampled high.
REQ-021 upd_req SHALL be low for exactly 1 cycle between phases (the cycle after ack); DONE lasts 1 cycle and then returns to IDLE.
REQ-022 upd_ack SHALL be ignored while upd_req = 0.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 A refr while not in IDLE SHALL set overrun; the sequence SHALL NOT restart and SHALL continue unaffected.
REQ-025 A p_tick with pixel_x == 0 && pixel_y == 0 while busy SHALL set overrun.
REQ-026 pause asserted mid-sequence SHALL NOT abort the sequence; the sequence completes.
REQ-027 err_clr SHALL clear overrun and timeout_err the next cycle; a set event in the same cycle as err_clr SHALL win (the flag stays 1).

Reset
REQ-028 When reset == 0 at a clk edge, the block SHALL enter this state: FSM = IDLE, upd_req = 0, upd_phase = 0, frame_tick = 0, busy = 0, frame_cnt = 0, overrun = 0, timeout_err = 0, watchdog count = 0.
REQ-029 Reset asserted mid-sequence SHALL drop upd_req in the cycle following the reset edge, and no phase SHALL resume.

Configuration
REQ-030 Macro WATCHDOG_EN defined: a per-phase cycle counter SHALL clear on entry to each phase; when it reaches TIMEOUT without ack, the block SHALL set timeout_err, deassert upd_req and advance as if acked.
REQ-031 Macro WATCHDOG_EN undefined: no watchdog counter SHALL exist, phases SHALL wait for ack indefinitely, and timeout_err SHALL be tied to 0.

Structure
REQ-032 Package vga_sched_pkg SHALL hold the FSM state typedef, the phase code constants (PH_PADDLE/PH_BALL/PH_COLLIDE) and the H_ACTIVE = 640 / V_ACTIVE = 480 defaults.
REQ-033 The watchdog SHALL be the sub-module vga_phase_watchdog (ports: clk, reset, start, ack, expired), instantiated only under WATCHDOG_EN.

Verification
REQ-034 Scenario: reset low for 3 clks, then release -> all outputs 0, FSM IDLE, frame_cnt = 0.
REQ-035 Scenario: drive pixel_y = 480, pixel_x = 0, p_tick -> frame_tick high exactly 1 cycle later; frame_cnt = 1; upd_req = 1 with phase 0; ack at each phase after 5 cycles -> phase sequence 0, 1, 2, then busy = 0.
REQ-036 Scenario: pause = 1 across 3 refr events -> frame_cnt = 3; upd_req never asserted.
REQ-037 Scenario: withhold ack in BALL; next pixel_y = 0 tick -> overrun = 1; err_clr -> overrun = 0.
REQ-038 Scenario: WATCHDOG_EN defined, TIMEOUT = 16, no ack in PADDLE -> after 16 cycles timeout_err = 1 and phase advances to 1; WATCHDOG_EN undefined -> remains in PADDLE.
REQ-039 Scenario: frame_cnt preloaded to 0xFFFF by 65535 refr events, one more refr -> frame_cnt = 0x0000; then reset asserted in COLLIDE -> upd_req = 0 on the next cycle.
